// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/done handshake and registered result/flags; define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             input_Start,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [3:0]       input_ALUOp,
  output logic [WIDTH-1:0] output_ALU,
  output logic [WIDTH-1:0] output_High,
  output logic             output_Zero,
  output logic             output_Negative,
  output logic             output_Carry,
  output logic             output_Overflow,
  output logic             output_Busy,
  output logic             output_Done,
  output logic             output_Error
);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLA = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_DBL = 4'b1001;
  localparam logic [3:0] OP_PSB = 4'b1100;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
  typedef enum logic [1:0] {IDLE, EXEC_MUL, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
  state_t state, state_n;
  logic accept, load, err_r;
  logic [SHW-1:0] sh;
  logic [WIDTH:0] sum, dif, shl, shr, sar;
  logic add_v, sub_v;
  logic [WIDTH-1:0] res, alu_n;
  logic c, v, err, z_n, n_n, c_n, v_n, e_n;
  assign accept = input_Start && state == IDLE;
  assign sh = input_B[SHW-1:0];
  assign sum = {1'b0, input_A} + {1'b0, input_B};
  assign dif = {1'b0, input_A} - {1'b0, input_B};
  assign add_v = (input_A[WIDTH-1] == input_B[WIDTH-1]) && (sum[WIDTH-1] != input_A[WIDTH-1]);
  assign sub_v = (input_A[WIDTH-1] != input_B[WIDTH-1]) && (dif[WIDTH-1] != input_A[WIDTH-1]);
  assign shl = {1'b0, input_A} << sh;
  assign shr = {input_A, 1'b0} >> sh;
  assign sar = $signed({input_A, 1'b0}) >>> sh;
`ifdef SEQ_ALU_MUL_EN
  logic is_mul, mul_last;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [SHW-1:0] cnt;
  logic [WIDTH:0] acc;
  assign is_mul = input_ALUOp == OP_MUL;
  assign acc = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_n = {acc, prod[WIDTH-1:1]};
  assign mul_last = state == EXEC_MUL && cnt == SHW'(WIDTH - 1);
  assign load = (accept && !is_mul) || mul_last;
  // multiplier datapath: one multiplier bit consumed per EXEC_MUL cycle
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      mcand <= '0;
      prod <= '0;
      cnt <= '0;
    end else if (accept && is_mul) begin
      mcand <= input_A;
      prod <= {{WIDTH{1'b0}}, input_B};
      cnt <= '0;
    end else if (state == EXEC_MUL) begin
      prod <= prod_n;
      cnt <= cnt + SHW'(1);
    end
  // upper product half, cleared by any other completed op
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) output_High <= '0;
    else if (load) output_High <= mul_last ? prod_n[2*WIDTH-1:WIDTH] : '0;
  // next-state: MUL detours through EXEC_MUL, everything else completes next cycle
  always_comb begin
    state_n = state;
    if (accept) state_n = is_mul ? EXEC_MUL : DONE;
    else if (mul_last) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
`else
  assign load = accept;
  assign output_High = '0;
  // next-state: every op completes in the cycle after acceptance
  always_comb begin
    state_n = state;
    if (accept) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
`endif
  // state register
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  // single-cycle result and carry/overflow, evaluated on the operands being accepted
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    err = 1'b0;
    case (input_ALUOp)
      OP_ADD: begin res = sum[WIDTH-1:0]; c = sum[WIDTH]; v = add_v; end
      OP_SUB: begin res = dif[WIDTH-1:0]; c = dif[WIDTH]; v = sub_v; end
      OP_AND: res = input_A & input_B;
      OP_OR:  res = input_A | input_B;
      OP_XOR: res = input_A ^ input_B;
      OP_SLL, OP_SLA: begin res = shl[WIDTH-1:0]; c = shl[WIDTH]; end
      OP_SRL: begin res = shr[WIDTH:1]; c = shr[0]; end
      OP_SRA: begin res = sar[WIDTH:1]; c = sar[0]; end
      OP_DBL: begin res = {sum[WIDTH-2:0], 1'b0}; c = sum[WIDTH-1]; v = add_v; end
      OP_PSB: res = input_B;
      default: err = 1'b1;
    endcase
  end
  // values to register: multiplier result when it finishes, else the single-cycle result
  always_comb begin
    alu_n = res;
    z_n = !err && res == '0;
    n_n = res[WIDTH-1];
    c_n = c;
    v_n = v;
    e_n = err;
`ifdef SEQ_ALU_MUL_EN
    if (mul_last) begin
      alu_n = prod_n[WIDTH-1:0];
      z_n = prod_n[WIDTH-1:0] == '0;
      n_n = prod_n[WIDTH-1];
      c_n = prod_n[2*WIDTH-1:WIDTH] != '0;
      v_n = 1'b0;
      e_n = 1'b0;
    end
`endif
  end
  // result and flags hold until the next completed operation
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      output_ALU <= '0;
      output_Zero <= 1'b0;
      output_Negative <= 1'b0;
      output_Carry <= 1'b0;
      output_Overflow <= 1'b0;
      err_r <= 1'b0;
    end else if (load) begin
      output_ALU <= alu_n;
      output_Zero <= z_n;
      output_Negative <= n_n;
      output_Carry <= c_n;
      output_Overflow <= v_n;
      err_r <= e_n;
    end
  assign output_Busy = state != IDLE;
  assign output_Done = state == DONE;
  assign output_Error = output_Done && err_r;
endmodule
